// File: rtl/npu_pkg.sv
// AXI encodings and engine state types shared by the NPU memory-side blocks.
package npu_pkg;
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
   typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;
endpackage

// File: rtl/axi_mem_sram.sv
// Simple dual-port array: one byte-enabled write port, one synchronous read port.
// Read data appears one cycle after re_i. It holds while re_i is low. A same-cycle write to the read word returns the old data.
module axi_mem_sram #(
   parameter int unsigned DATA_W = 128,
   parameter int unsigned DEPTH  = 4096
) (
   input  logic                     clk_i,
   input  logic                     we_i,
   input  logic [DATA_W/8-1:0]      wbe_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [DATA_W-1:0]        wdata_i,
   input  logic                     re_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [DATA_W-1:0]        rdata_o
);
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (re_i) rdata_q <= mem_q[raddr_i];
      if (we_i) begin
         for (int b = 0; b < DATA_W/8; b++) begin
            if (wbe_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
         end
      end
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave memory model. It has independent write and read engines, each with one outstanding burst, over a read-first SRAM.
// AR to first R takes 2 cycles and last W to B takes 1 cycle. R and B hold until accepted. R streams 1 beat/cycle while rready stays high.
module axi_mem_responder
   import npu_pkg::*;
#(
   parameter int unsigned           AXI_DATA_W = 128,
   parameter int unsigned           AXI_ADDR_W = 40,
   parameter int unsigned           MEM_WORDS  = 4096,
   parameter logic [AXI_ADDR_W-1:0] BASE_ADDR  = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [AXI_ADDR_W-1:0]   s_axi_awaddr,
   input  logic [7:0]              s_axi_awlen,
   input  logic [2:0]              s_axi_awsize,
   input  logic [1:0]              s_axi_awburst,
   input  logic                    s_axi_awvalid,
   output logic                    s_axi_awready,
   input  logic [AXI_DATA_W-1:0]   s_axi_wdata,
   input  logic [AXI_DATA_W/8-1:0] s_axi_wstrb,
   input  logic                    s_axi_wlast,
   input  logic                    s_axi_wvalid,
   output logic                    s_axi_wready,
   output logic [1:0]              s_axi_bresp,
   output logic                    s_axi_bvalid,
   input  logic                    s_axi_bready,
   input  logic [AXI_ADDR_W-1:0]   s_axi_araddr,
   input  logic [7:0]              s_axi_arlen,
   input  logic [2:0]              s_axi_arsize,
   input  logic [1:0]              s_axi_arburst,
   input  logic                    s_axi_arvalid,
   output logic                    s_axi_arready,
   output logic [AXI_DATA_W-1:0]   s_axi_rdata,
   output logic [1:0]              s_axi_rresp,
   output logic                    s_axi_rlast,
   output logic                    s_axi_rvalid,
   input  logic                    s_axi_rready
);
   localparam int unsigned STRB_W  = AXI_DATA_W/8;
   localparam int unsigned BYTE_SH = $clog2(STRB_W);
   localparam int unsigned WORD_AW = $clog2(MEM_WORDS);
   localparam logic [AXI_ADDR_W-1:0] BEAT_BYTES = AXI_ADDR_W'(STRB_W);
   localparam logic [AXI_ADDR_W-1:0] MEM_BYTES  = AXI_ADDR_W'(MEM_WORDS * STRB_W);

   // The subtraction wraps, so addresses below BASE_ADDR land far above MEM_BYTES.
   function automatic logic in_range(input logic [AXI_ADDR_W-1:0] a);
      return (a - BASE_ADDR) < MEM_BYTES;
   endfunction

   function automatic logic [WORD_AW-1:0] word_idx(input logic [AXI_ADDR_W-1:0] a);
      return WORD_AW'((a - BASE_ADDR) >> BYTE_SH);
   endfunction

   function automatic logic hdr_err(input logic [1:0] burst, input logic [2:0] size,
                                    input logic [AXI_ADDR_W-1:0] a);
      return (burst != AXI_BURST_INCR) || (size != 3'(BYTE_SH)) || (a[BYTE_SH-1:0] != '0);
   endfunction

   w_state_e              w_state_q, w_state_d;
   logic [AXI_ADDR_W-1:0] waddr_q, waddr_d;
   logic [7:0]            wlen_q, wlen_d, wcnt_q, wcnt_d;
   logic                  whdr_err_q, whdr_err_d, wslverr_q, wslverr_d;
   logic [1:0]            bresp_q, bresp_d;
   logic                  awready_q, wready_q, bvalid_q;

   r_state_e              r_state_q, r_state_d;
   logic [AXI_ADDR_W-1:0] raddr_q, raddr_d;
   logic [7:0]            rlen_q, rlen_d, rcnt_q, rcnt_d;
   logic                  rhdr_err_q, rhdr_err_d, rbeat_err_q, rbeat_err_d;
   logic                  arready_q, rvalid_q;

   logic                  mem_we, mem_re, w_last_beat;
   logic [AXI_DATA_W-1:0] mem_rdata;

   assign w_last_beat = (wcnt_q == wlen_q);

   always_comb begin
      w_state_d  = w_state_q;
      waddr_d    = waddr_q;
      wlen_d     = wlen_q;
      wcnt_d     = wcnt_q;
      whdr_err_d = whdr_err_q;
      wslverr_d  = wslverr_q;
      bresp_d    = bresp_q;
      mem_we     = 1'b0;
      case (w_state_q)
         W_IDLE: if (s_axi_awvalid && awready_q) begin
            waddr_d    = s_axi_awaddr;
            wlen_d     = s_axi_awlen;
            wcnt_d     = 8'd0;
            whdr_err_d = hdr_err(s_axi_awburst, s_axi_awsize, s_axi_awaddr);
            wslverr_d  = whdr_err_d;
            w_state_d  = W_DATA;
         end
         W_DATA: if (s_axi_wvalid && wready_q) begin
            mem_we    = !whdr_err_q && in_range(waddr_q);
            wslverr_d = wslverr_q || !in_range(waddr_q) || (s_axi_wlast != w_last_beat);
            waddr_d   = waddr_q + BEAT_BYTES;
            wcnt_d    = wcnt_q + 8'd1;
            if (w_last_beat) begin
               bresp_d   = wslverr_d ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
               w_state_d = W_RESP;
            end
         end
         W_RESP: if (s_axi_bready && bvalid_q) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   // Each fetch presents the word for the next beat; the SRAM output register holds it through stalls.
   always_comb begin
      r_state_d   = r_state_q;
      raddr_d     = raddr_q;
      rlen_d      = rlen_q;
      rcnt_d      = rcnt_q;
      rhdr_err_d  = rhdr_err_q;
      rbeat_err_d = rbeat_err_q;
      mem_re      = 1'b0;
      case (r_state_q)
         R_IDLE: if (s_axi_arvalid && arready_q) begin
            raddr_d    = s_axi_araddr;
            rlen_d     = s_axi_arlen;
            rcnt_d     = 8'd0;
            rhdr_err_d = hdr_err(s_axi_arburst, s_axi_arsize, s_axi_araddr);
            r_state_d  = R_FETCH;
         end
         R_FETCH: begin
            mem_re      = 1'b1;
            rbeat_err_d = rhdr_err_q || !in_range(raddr_q);
            raddr_d     = raddr_q + BEAT_BYTES;
            r_state_d   = R_DATA;
         end
         R_DATA: if (s_axi_rready && rvalid_q) begin
            if (rcnt_q != rlen_q) begin
               mem_re      = 1'b1;
               rbeat_err_d = rhdr_err_q || !in_range(raddr_q);
               raddr_d     = raddr_q + BEAT_BYTES;
               rcnt_d      = rcnt_q + 8'd1;
            end else begin
               r_state_d = R_IDLE;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_state_q   <= W_IDLE;
         waddr_q     <= '0;
         wlen_q      <= '0;
         wcnt_q      <= '0;
         whdr_err_q  <= 1'b0;
         wslverr_q   <= 1'b0;
         bresp_q     <= AXI_RESP_OKAY;
         awready_q   <= 1'b0;
         wready_q    <= 1'b0;
         bvalid_q    <= 1'b0;
         r_state_q   <= R_IDLE;
         raddr_q     <= '0;
         rlen_q      <= '0;
         rcnt_q      <= '0;
         rhdr_err_q  <= 1'b0;
         rbeat_err_q <= 1'b0;
         arready_q   <= 1'b0;
         rvalid_q    <= 1'b0;
      end else begin
         w_state_q   <= w_state_d;
         waddr_q     <= waddr_d;
         wlen_q      <= wlen_d;
         wcnt_q      <= wcnt_d;
         whdr_err_q  <= whdr_err_d;
         wslverr_q   <= wslverr_d;
         bresp_q     <= bresp_d;
         awready_q   <= (w_state_d == W_IDLE);
         wready_q    <= (w_state_d == W_DATA);
         bvalid_q    <= (w_state_d == W_RESP);
         r_state_q   <= r_state_d;
         raddr_q     <= raddr_d;
         rlen_q      <= rlen_d;
         rcnt_q      <= rcnt_d;
         rhdr_err_q  <= rhdr_err_d;
         rbeat_err_q <= rbeat_err_d;
         arready_q   <= (r_state_d == R_IDLE);
         rvalid_q    <= (r_state_d == R_DATA);
      end
   end

   axi_mem_sram #(
      .DATA_W (AXI_DATA_W),
      .DEPTH  (MEM_WORDS)
   ) u_sram (
      .clk_i   (clk),
      .we_i    (mem_we),
      .wbe_i   (s_axi_wstrb),
      .waddr_i (word_idx(waddr_q)),
      .wdata_i (s_axi_wdata),
      .re_i    (mem_re),
      .raddr_i (word_idx(raddr_q)),
      .rdata_o (mem_rdata)
   );

   assign s_axi_awready = awready_q;
   assign s_axi_wready  = wready_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = bresp_q;
   assign s_axi_arready = arready_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rdata   = (rvalid_q && !rbeat_err_q) ? mem_rdata : '0;
   assign s_axi_rresp   = (rvalid_q && rbeat_err_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
   assign s_axi_rlast   = rvalid_q && (rcnt_q == rlen_q);
endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: a word-level memory model fills R/B scoreboards that monitors drain.
module tb_axi_mem_responder;
   logic         clk = 1'b0;
   logic         rst;
   logic [39:0]  awaddr, araddr;
   logic [7:0]   awlen, arlen;
   logic [2:0]   awsize, arsize;
   logic [1:0]   awburst, arburst;
   logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic [127:0] wdata, rdata;
   logic [15:0]  wstrb;
   logic [1:0]   bresp, rresp;
   logic         arvalid, arready, rlast, rvalid, rready;

   typedef struct {
      logic [127:0] d;
      logic [1:0]   r;
      logic         l;
   } rexp_t;

   rexp_t        rq[$];
   logic [1:0]   bq[$];
   logic [127:0] mem_m [int];
   int           checks = 0;
   int           passes = 0;
   bit           stall_q = 0;
   logic [127:0] hold_d;
   logic         hold_l;

   always #5 clk = ~clk;

   axi_mem_responder dut (
      .clk(clk), .rst(rst),
      .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize), .s_axi_awburst(awburst),
      .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
      .s_axi_wready(wready),
      .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
      .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize), .s_axi_arburst(arburst),
      .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast), .s_axi_rvalid(rvalid),
      .s_axi_rready(rready)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // R monitor: stall stability plus in-order scoreboard compare.
   always @(negedge clk) begin
      if (rst) begin
         stall_q = 0;
      end else begin
         if (stall_q) begin
            chk("r_stall_vld", rvalid, 1);
            chk("r_stall_data", rdata, hold_d);
            chk("r_stall_last", rlast, hold_l);
         end
         stall_q = rvalid && !rready;
         hold_d  = rdata;
         hold_l  = rlast;
         if (rvalid && rready) begin
            if (rq.size() == 0) chk("r_unexpected", rq.size(), 1);
            else begin
               rexp_t e;
               e = rq.pop_front();
               chk("r_data", rdata, e.d);
               chk("r_resp", rresp, e.r);
               chk("r_last", rlast, e.l);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && bvalid && bready) begin
         if (bq.size() == 0) chk("b_unexpected", bq.size(), 1);
         else chk("b_resp", bresp, bq.pop_front());
      end
   end

   task automatic wait_hs(input int ch, input string tag);
      bit got;
      int n;
      got = 0;
      n = 0;
      while (!got && n < 100) begin
         @(negedge clk);
         got = (ch == 0) ? awready : (ch == 1) ? wready : arready;
         @(posedge clk); #1;
         n++;
      end
      if (!got) chk(tag, got, 1);
   endtask

   task automatic wr_burst(input logic [39:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [2:0] size, input logic [127:0] d0, input logic [15:0] strb,
                           input int abort_at);
      bit hdr_e, err;
      logic [39:0]  a;
      logic [127:0] cur, dat;
      int w;
      hdr_e = (burst != 2'b01) || (size != 3'd4) || (addr[3:0] != 4'h0);
      err = hdr_e;
      for (int i = 0; i <= int'(len); i++) begin
         a = addr + 40'(i * 16);
         if (a >= 40'h10000) err = 1;
      end
      if (abort_at < 0) bq.push_back(err ? 2'b10 : 2'b00);
      awaddr = addr; awlen = len; awburst = burst; awsize = size; awvalid = 1;
      wait_hs(0, "aw_timeout");
      awvalid = 0;
      for (int i = 0; i <= int'(len); i++) begin
         if (abort_at >= 0 && i == abort_at) return;
         dat = d0 + 128'(i);
         wdata = dat; wstrb = strb; wlast = (i == int'(len)); wvalid = 1;
         wait_hs(1, "w_timeout");
         a = addr + 40'(i * 16);
         if (!hdr_e && a < 40'h10000) begin
            w = int'(a >> 4);
            cur = mem_m.exists(w) ? mem_m[w] : '0;
            for (int b = 0; b < 16; b++) if (strb[b]) cur[b*8 +: 8] = dat[b*8 +: 8];
            mem_m[w] = cur;
         end
      end
      wvalid = 0; wlast = 0;
      @(negedge clk);
      chk("b_latency", bvalid, 1);
      @(posedge clk); #1;
   endtask

   task automatic rd_burst(input logic [39:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [2:0] size, input bit bp);
      bit hdr_e, e;
      logic [39:0] a;
      rexp_t x;
      int n;
      hdr_e = (burst != 2'b01) || (size != 3'd4) || (addr[3:0] != 4'h0);
      for (int i = 0; i <= int'(len); i++) begin
         a = addr + 40'(i * 16);
         e = hdr_e || (a >= 40'h10000);
         x.d = (e || !mem_m.exists(int'(a >> 4))) ? '0 : mem_m[int'(a >> 4)];
         x.r = e ? 2'b10 : 2'b00;
         x.l = (i == int'(len));
         rq.push_back(x);
      end
      rready = !bp;
      araddr = addr; arlen = len; arburst = burst; arsize = size; arvalid = 1;
      wait_hs(2, "ar_timeout");
      arvalid = 0;
      @(negedge clk);
      chk("r_latency_fetch", rvalid, 0);
      @(negedge clk);
      chk("r_latency_first", rvalid, 1);
      n = 0;
      while (rq.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         if (bp) rready = ~rready;
         n++;
      end
      chk("r_burst_done", rq.size(), 0);
      rready = 1;
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1; awvalid = 0; wvalid = 0; wlast = 0; arvalid = 0; bready = 1; rready = 1;
      awaddr = '0; awlen = '0; awsize = '0; awburst = '0; wdata = '0; wstrb = '0;
      araddr = '0; arlen = '0; arsize = '0; arburst = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_awready", awready, 0);
      chk("rst_wready", wready, 0);
      chk("rst_bvalid", bvalid, 0);
      chk("rst_bresp", bresp, 0);
      chk("rst_arready", arready, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_rresp", rresp, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_rlast", rlast, 0);
      rst = 0;
      @(posedge clk); #1;

      wr_burst(40'h100, 8'd3, 2'b01, 3'd4, 128'hA0, 16'hFFFF, -1);
      rd_burst(40'h100, 8'd3, 2'b01, 3'd4, 0);

      wr_burst(40'h300, 8'd0, 2'b01, 3'd4, '1, 16'hFFFF, -1);
      wr_burst(40'h300, 8'd0, 2'b01, 3'd4, 128'h11223344_55667788_99AABBCC_DDEEFF22, 16'h0001, -1);
      rd_burst(40'h300, 8'd0, 2'b01, 3'd4, 0);

      wr_burst(40'h200, 8'd7, 2'b01, 3'd4, 128'hC0DE_0000_0000_0000_0000_0000_0000_00C0, 16'hFFFF, -1);
      rd_burst(40'h200, 8'd7, 2'b01, 3'd4, 1);

      wr_burst(40'h100, 8'd1, 2'b00, 3'd4, 128'hDEAD, 16'hFFFF, -1);
      rd_burst(40'h100, 8'd3, 2'b01, 3'd4, 0);

      wr_burst(40'hFFF0, 8'd0, 2'b01, 3'd4, 128'h5555_AAAA, 16'hFFFF, -1);
      rd_burst(40'hFFF0, 8'd1, 2'b01, 3'd4, 0);

      wr_burst(40'h400, 8'd15, 2'b01, 3'd4, 128'h7700, 16'hFFFF, 5);
      rst = 1;
      #1;
      chk("midrst_awready", awready, 0);
      chk("midrst_wready", wready, 0);
      chk("midrst_bvalid", bvalid, 0);
      chk("midrst_arready", arready, 0);
      chk("midrst_rvalid", rvalid, 0);
      wvalid = 0; wlast = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      repeat (10) @(posedge clk);
      #1;
      chk("postrst_no_bvalid", bvalid, 0);
      wr_burst(40'h400, 8'd15, 2'b01, 3'd4, 128'h9000, 16'hFFFF, -1);
      rd_burst(40'h400, 8'd15, 2'b01, 3'd4, 0);

      chk("r_sb_empty", rq.size(), 0);
      chk("b_sb_empty", bq.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
